mmio_store_monitor: RTL and testbench
=====================================

Name: mmio_store_monitor

Overview:
- Memory-mapped store sink on the processor's data bus; consumes `adr`, `writedata` and `memwrite` from `top`.
- Stores to `LOG_ADR` are buffered in a FIFO and drained to a consumer over a valid/ready port.
- A store to `DONE_ADR` ends the run and latches a pass/fail verdict against `EXPECT`.
- Replaces ad-hoc address checks in benches; also usable as an on-chip debug/console port.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- LOG_ADR, 32'h80, address whose stores are logged.
- DONE_ADR, 32'h4C, address whose store terminates the run.
- EXPECT, 32'h5, value required at DONE_ADR for pass.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- adr  in  32  byte address from processor.
- writedata  in  32  store data from processor.
- memwrite  in  1  store strobe; one cycle high = one store.
- out_valid  out  1  FIFO head valid.
- out_data  out  32  FIFO head word.
- out_ready  in  1  consumer accepts head this cycle.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a log store was dropped.
- done  out  1  sticky: DONE_ADR store seen.
- pass  out  1  verdict; valid only when done=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid, count, overflow, done and pass go to 0 immediately.
  - FIFO pointers clear; state=RUN; out_data=0.
- FSM states:
  - RUN: the only state that captures stores.
  - HALT: entered on the DONE_ADR store; left only by reset.
- Store definition: a rising clk edge with memwrite=1. Each such cycle is one store, with no edge detection. Stores to any other address are ignored.
- Push (RUN, adr==LOG_ADR):
  - Word is written at the tail pointer.
  - count updates at the same edge; the word is visible on out_data/out_valid after that edge (0-cycle fall-through, 1-cycle latency).
- Pop: an edge with out_valid=1 and out_ready=1 removes the head. out_ready while empty has no effect.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - Allowed when full: the pop frees the slot, the push is accepted, overflow is not set.
- Full (count==DEPTH), push without pop: word is dropped, overflow←1 (sticky until reset), FIFO contents unchanged.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH; count is the distinct full/empty discriminator.
- Done (RUN, adr==DONE_ADR):
  - done←1, pass←(writedata==EXPECT), state←HALT, at that edge.
  - The done store is never logged, even if LOG_ADR==DONE_ADR.
- HALT:
  - All further stores are ignored; done and pass are frozen.
  - Draining continues normally; overflow cannot be newly set.
- out_data when empty: holds the last value presented; consumers must qualify with out_valid.
- Reset mid-operation: all buffered words are discarded; no partial state survives.

Test Plan:
1. Reset held low 3 cycles, then released → out_valid=0, count=0, done=0, pass=0, overflow=0.
2. Stores 0x11, 0x22, 0x33 to 0x80 with out_ready=0 → count=3. Raise out_ready → out_data is 0x11, 0x22, 0x33 on consecutive cycles; count reaches 0; out_valid drops after the third pop.
3. Nine stores to 0x80 with out_ready=0 (DEPTH=8) → count=8 and overflow=1; drain yields the first eight words only.
4. FIFO full with out_ready=1, store 0xAA → count stays 8, overflow=0, 0xAA appears last in the drain order.
5. Store 0x5 to 0x4C → done=1, pass=1 on the next cycle. A later store 0x77 to 0x80 is not logged. Repeat from reset with 0x6 → done=1, pass=0.
6. Assert reset=0 asynchronously mid-cycle with count=4 → count, out_valid and done go to 0 without waiting for a clk edge; after release, a store to 0x80 works normally.

Source files
------------

// File: rtl/mmio_store_monitor.sv
// mmio_store_monitor
// Store sink on the processor data bus. Stores to LOG_ADR are queued in a
// small FIFO and drained over a valid/ready port. A store to DONE_ADR ends
// the run and latches a pass/fail verdict (written value vs EXPECT).
// DEPTH must be a power of two and at least 2.

module mmio_store_monitor #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] LOG_ADR  = 32'h0000_0080,
    parameter logic [31:0] DONE_ADR = 32'h0000_004C,
    parameter logic [31:0] EXPECT   = 32'h0000_0005
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              adr,
    input  logic [31:0]              writedata,
    input  logic                     memwrite,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     pass
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Registered state
    state_t          state_q,     state_d;
    logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]   count_q,     count_d;
    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];
    logic [31:0]     out_data_q,  out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q,  overflow_d;
    logic            done_q,      done_d;
    logic            pass_q,      pass_d;

    // Decoded per-cycle events
    logic            log_hit_s;
    logic            done_hit_s;
    logic            pop_s;
    logic            full_s;
    logic            push_ok_s;
    logic            drop_s;

    // Classify the current bus cycle: log store, done store, pop, drop.
    // The done address wins over the log address so a terminating store is
    // never queued, even when both addresses are configured equal.
    always_comb begin
        log_hit_s  = 1'b0;
        done_hit_s = 1'b0;
        if (memwrite && (state_q == ST_RUN)) begin
            done_hit_s = (adr == DONE_ADR);
            log_hit_s  = (adr == LOG_ADR) && (adr != DONE_ADR);
        end else begin
            done_hit_s = 1'b0;
            log_hit_s  = 1'b0;
        end
        pop_s     = out_valid_q && out_ready;
        full_s    = (count_q == CNT_FULL);
        // A pop at the same edge frees the slot, so a full FIFO still accepts.
        push_ok_s = log_hit_s && (!full_s || pop_s);
        drop_s    = log_hit_s && full_s && !pop_s;
    end

    // Run/halt state machine and the done/pass verdict.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            ST_RUN: begin
                if (done_hit_s) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                    pass_d  = (writedata == EXPECT);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FIFO datapath: storage, pointers, occupancy, overflow and the head
    // register. The head is taken from the post-write storage image so a
    // word pushed into an empty FIFO appears on out_data right after the edge.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = writedata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        out_valid_d = (count_d != CNT_ZERO);
        // When empty the last presented word is held; consumers qualify
        // with out_valid.
        if (count_d != CNT_ZERO) begin
            out_data_d = mem_d[rd_ptr_d];
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Control and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= CNT_ZERO;
            out_data_q  <= 32'h0000_0000;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // FIFO storage; cleared on reset so no stale word survives a restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_mmio_store_monitor.sv
// Directed, table-driven bench for mmio_store_monitor (DEPTH=8).

module tb_mmio_store_monitor;

    localparam logic [31:0] LOG  = 32'h0000_0080;
    localparam logic [31:0] DN   = 32'h0000_004C;
    localparam logic [31:0] OTH  = 32'h0000_0084;

    logic        clk;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        overflow;
    logic        done;
    logic        pass;

    int checks;
    int failures;

    typedef struct {
        bit          rst;
        bit          mw;
        logic [31:0] a;
        logic [31:0] wd;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_data;
        int          e_cnt;
        bit          e_ovf;
        bit          e_done;
        bit          e_pass;
    } vec_t;

    vec_t vecs[$];

    mmio_store_monitor #(
        .DEPTH    (8),
        .LOG_ADR  (32'h0000_0080),
        .DONE_ADR (32'h0000_004C),
        .EXPECT   (32'h0000_0005)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit ev, input logic [31:0] ed,
                           input int ec, input bit eo, input bit edn, input bit ep);
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, " out_data"},  out_data, ed);
        chk({tag, " count"},     {28'd0, count}, ec);
        chk({tag, " overflow"},  {31'd0, overflow}, {31'd0, eo});
        chk({tag, " done"},      {31'd0, done}, {31'd0, edn});
        chk({tag, " pass"},      {31'd0, pass}, {31'd0, ep});
    endtask

    task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        @(negedge clk);
        memwrite  = mw;
        adr       = a;
        writedata = wd;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        memwrite  = 1'b0;
        out_ready = 1'b0;
        adr       = 32'h0;
        writedata = 32'h0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    function automatic void add(bit rst, bit mw, logic [31:0] a, logic [31:0] wd, bit rdy,
                                bit ev, logic [31:0] ed, int ec, bit eo, bit edn, bit ep);
        vec_t v;
        v.rst = rst; v.mw = mw; v.a = a; v.wd = wd; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_cnt = ec; v.e_ovf = eo;
        v.e_done = edn; v.e_pass = ep;
        vecs.push_back(v);
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        memwrite  = 1'b0;
        adr       = 32'h0;
        writedata = 32'h0;
        out_ready = 1'b0;

        // Reset state
        add(1, 0, 0, 0, 0,   0, 32'h0, 0, 0, 0, 0);
        // Three logged stores, then drain in order
        add(0, 1, LOG, 32'h11, 0,   1, 32'h11, 1, 0, 0, 0);
        add(0, 1, LOG, 32'h22, 0,   1, 32'h11, 2, 0, 0, 0);
        add(0, 1, LOG, 32'h33, 0,   1, 32'h11, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1,          1, 32'h22, 2, 0, 0, 0);
        add(0, 0, 0, 0, 1,          1, 32'h33, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1,          0, 32'h33, 0, 0, 0, 0);
        // out_ready while empty does nothing
        add(0, 0, 0, 0, 1,          0, 32'h33, 0, 0, 0, 0);
        // Nine stores into an 8-deep FIFO: the ninth is dropped
        for (int i = 0; i < 8; i++)
            add(0, 1, LOG, 32'h100 + i, 0,   1, 32'h100, i + 1, 0, 0, 0);
        add(0, 1, LOG, 32'h108, 0,   1, 32'h100, 8, 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 0, 0, 1,   (k < 8), (k < 8) ? 32'h100 + k : 32'h107, 8 - k, 1, 0, 0);
        // Fresh run: full FIFO with simultaneous push and pop
        add(1, 0, 0, 0, 0,   0, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, LOG, 32'h200 + i, 0,   1, 32'h200, i + 1, 0, 0, 0);
        add(0, 1, LOG, 32'hAA, 1,   1, 32'h201, 8, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 0, 0, 1,   (k < 8), (k <= 6) ? 32'h201 + k : 32'hAA, 8 - k, 0, 0, 0);
        // Other address ignored
        add(0, 1, OTH, 32'h55, 0,   0, 32'hAA, 0, 0, 0, 0);
        // Push into empty with out_ready high: no pop of an invalid head
        add(0, 1, LOG, 32'h66, 1,   1, 32'h66, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1,          0, 32'h66, 0, 0, 0, 0);
        // Done with the expected value, later stores ignored, verdict frozen
        add(0, 1, DN,  32'h5,  0,   0, 32'h66, 0, 0, 1, 1);
        add(0, 1, LOG, 32'h77, 0,   0, 32'h66, 0, 0, 1, 1);
        add(0, 1, DN,  32'h6,  0,   0, 32'h66, 0, 0, 1, 1);
        // Fresh run with a failing verdict; draining continues after halt
        add(1, 0, 0, 0, 0,   0, 32'h0, 0, 0, 0, 0);
        add(0, 1, LOG, 32'h12, 0,   1, 32'h12, 1, 0, 0, 0);
        add(0, 1, DN,  32'h6,  0,   1, 32'h12, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1,          0, 32'h12, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                step(vecs[i].mw, vecs[i].a, vecs[i].wd, vecs[i].rdy);
            end
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                    vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_done, vecs[i].e_pass);
        end

        // Asynchronous reset mid-cycle with four words buffered and done set
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, LOG, 32'h31 + i, 1'b0);
        step(1'b1, DN, 32'h5, 1'b0);
        chk_all("pre_async", 1'b1, 32'h31, 4, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        memwrite = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, LOG, 32'h99, 1'b0);
        chk_all("post_rst", 1'b1, 32'h99, 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk_all("post_rst_pop", 1'b0, 32'h99, 0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
